// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module      : md_unit
// Description : Fixed-latency multiply/divide unit holding the HI/LO
//               registers (E stage). Runs MULT/MULTU/DIV/DIVU, takes
//               MTHI/MTLO writes and serves MFHI/MFLO reads combinationally.
//               Optional macro MD_MADD_EN adds MADD/MADDU/MSUB/MSUBU
//               (codes 9-12); without it those codes behave as NONE.
// Revision    : 1.0 - initial release
// ============================================================================
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        cancel,
    output logic        busy,
    output logic        busy_stall,
    output logic [31:0] hl_out
);

    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MTHI  = 4'd5;
    localparam logic [3:0] c_OP_MTLO  = 4'd6;
    localparam logic [3:0] c_OP_MFHI  = 4'd7;
    localparam logic [3:0] c_OP_MFLO  = 4'd8;
`ifdef MD_MADD_EN
    localparam logic [3:0] c_OP_MADD  = 4'd9;
    localparam logic [3:0] c_OP_MADDU = 4'd10;
    localparam logic [3:0] c_OP_MSUB  = 4'd11;
    localparam logic [3:0] c_OP_MSUBU = 4'd12;
`endif

    localparam logic [3:0] c_MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] c_DIV_N  = 4'(DIV_CYCLES);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic        pend_we_q, pend_we_d;

    // Opcode decode and acceptance
    logic w_is_mul, w_is_div, w_is_compute, w_accept;
    assign w_is_mul = (md_op == c_OP_MULT) || (md_op == c_OP_MULTU);
    assign w_is_div = (md_op == c_OP_DIV)  || (md_op == c_OP_DIVU);
`ifdef MD_MADD_EN
    logic w_is_madd;
    assign w_is_madd    = (md_op == c_OP_MADD) || (md_op == c_OP_MADDU) ||
                          (md_op == c_OP_MSUB) || (md_op == c_OP_MSUBU);
    assign w_is_compute = w_is_mul | w_is_div | w_is_madd;
`else
    assign w_is_compute = w_is_mul | w_is_div;
`endif
    assign w_accept = start & ~cancel & (state_q == S_IDLE);

    // Products: the low 64 bits of a product of sign-extended operands
    // equal the exact signed 32x32 product.
    logic [63:0] w_prod_s, w_prod_u;
    assign w_prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    assign w_prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Division on magnitudes, then sign fix-up: quotient negative when the
    // operand signs differ, remainder follows the dividend. A zero divisor
    // is replaced by 1 only to keep the datapath defined; its result is
    // never committed.
    logic        w_div_signed, w_rs_neg, w_rt_neg, w_rt_zero;
    logic [31:0] w_num, w_den, w_uq, w_ur, w_quot, w_rem;
    assign w_div_signed = (md_op == c_OP_DIV);
    assign w_rs_neg     = w_div_signed & rs_val[31];
    assign w_rt_neg     = w_div_signed & rt_val[31];
    assign w_rt_zero    = (rt_val == 32'd0);
    assign w_num        = w_rs_neg ? (~rs_val + 32'd1) : rs_val;
    assign w_den        = w_rt_zero ? 32'd1 : (w_rt_neg ? (~rt_val + 32'd1) : rt_val);
    assign w_uq         = w_num / w_den;
    assign w_ur         = w_num % w_den;
    assign w_quot       = (w_rs_neg ^ w_rt_neg) ? (~w_uq + 32'd1) : w_uq;
    assign w_rem        = w_rs_neg ? (~w_ur + 32'd1) : w_ur;

`ifdef MD_MADD_EN
    // Accumulate against HI/LO as they stand at accept time
    logic [63:0] w_acc_prod, w_acc;
    assign w_acc_prod = ((md_op == c_OP_MADD) || (md_op == c_OP_MSUB)) ? w_prod_s : w_prod_u;
    assign w_acc      = ((md_op == c_OP_MSUB) || (md_op == c_OP_MSUBU)) ?
                        ({hi_q, lo_q} - w_acc_prod) : ({hi_q, lo_q} + w_acc_prod);
`endif

    // Next-state logic: accept in IDLE, count down in BUSY, commit on the last cycle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_we_d = pend_we_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_compute) begin
                        state_d   = S_BUSY;
                        cnt_d     = w_is_div ? c_DIV_N : c_MULT_N;
                        pend_we_d = 1'b1;
                        if (w_is_div) begin
                            pend_hi_d = w_rem;
                            pend_lo_d = w_quot;
                            pend_we_d = ~w_rt_zero;
                        end else if (w_is_mul) begin
                            {pend_hi_d, pend_lo_d} = (md_op == c_OP_MULT) ? w_prod_s : w_prod_u;
                        end
`ifdef MD_MADD_EN
                        else begin
                            {pend_hi_d, pend_lo_d} = w_acc;
                        end
`endif
                    end else if (md_op == c_OP_MTHI) begin
                        hi_d = rs_val;
                    end else if (md_op == c_OP_MTLO) begin
                        lo_d = rs_val;
                    end
                end
            end
            S_BUSY: begin
                if (cnt_q <= 4'd1) begin
                    state_d   = S_IDLE;
                    cnt_d     = 4'd0;
                    pend_we_d = 1'b0;
                    if (pend_we_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_we_q <= pend_we_d;
        end
    end

    assign busy       = (state_q == S_BUSY);
    assign busy_stall = busy | (start & w_is_compute & ~cancel);

    // HI/LO read port for MFHI/MFLO
    always_comb begin
        hl_out = 32'd0;
        if (md_op == c_OP_MFHI) begin
            hl_out = hi_q;
        end else if (md_op == c_OP_MFLO) begin
            hl_out = lo_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_unit
// Description : Self-checking bench for md_unit. Expected HI/LO pairs are
//               queued when an operation is issued and compared when busy
//               drops. Define MD_MADD_EN for both files to test MADD codes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        cancel;
    logic        busy;
    logic        busy_stall;
    logic [31:0] hl_out;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [63:0] sbq[$];

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .md_op      (md_op),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .cancel     (cancel),
        .busy       (busy),
        .busy_stall (busy_stall),
        .hl_out     (hl_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start  = 1'b0;
        md_op  = 4'd0;
        rs_val = 32'd0;
        rt_val = 32'd0;
        cancel = 1'b0;
    endtask

    task automatic read_hl(output logic [31:0] h, output logic [31:0] l);
        md_op = 4'd7;
        #1 h  = hl_out;
        md_op = 4'd8;
        #1 l  = hl_out;
        md_op = 4'd0;
    endtask

    // Reference behaviour of HI/LO after an accepted compute op
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, p;
        longint unsigned pu, acc;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd1: begin p = sa * sb; {m_hi, m_lo} = p; end
            4'd2: begin pu = longint'({32'd0, a}) * longint'({32'd0, b}); {m_hi, m_lo} = pu; end
            4'd3: if (b != 32'd0) begin
                      p    = sa / sb;
                      m_lo = p[31:0];
                      p    = sa % sb;
                      m_hi = p[31:0];
                  end
            4'd4: if (b != 32'd0) begin m_lo = a / b; m_hi = a % b; end
`ifdef MD_MADD_EN
            4'd9, 4'd10, 4'd11, 4'd12: begin
                if (op == 4'd9 || op == 4'd11) pu = sa * sb;
                else pu = longint'({32'd0, a}) * longint'({32'd0, b});
                acc = {m_hi, m_lo};
                acc = (op >= 4'd11) ? acc - pu : acc + pu;
                {m_hi, m_lo} = acc;
            end
`endif
            default: ;
        endcase
    endtask

    // Count remaining busy cycles, then compare HI/LO against the queued result
    task automatic finish_op(input string tag, input int exp_n, input int n0);
        int          n;
        logic [31:0] h, l;
        logic [63:0] e;
        n = n0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        check({tag, "_cycles"}, n, exp_n);
        read_hl(h, l);
        if (sbq.size() == 0) begin
            check({tag, "_sb_underflow"}, 0, 1);
        end else begin
            e = sbq.pop_front();
            check({tag, "_hi"}, h, e[63:32]);
            check({tag, "_lo"}, l, e[31:0]);
        end
    endtask

    task automatic run_compute(input string tag, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input int exp_n, input logic exp_stall);
        model(op, a, b);
        sbq.push_back({m_hi, m_lo});
        start  = 1'b1;
        md_op  = op;
        rs_val = a;
        rt_val = b;
        #1 check({tag, "_stall"}, busy_stall, exp_stall);
        tick();
        idle_inputs();
        finish_op(tag, exp_n, 0);
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] v);
        start  = 1'b1;
        md_op  = op;
        rs_val = v;
        tick();
        idle_inputs();
        if (op == 4'd5) m_hi = v;
        if (op == 4'd6) m_lo = v;
    endtask

    initial begin
        logic [31:0] h, l;
        int          madd_n;
        logic        madd_stall;
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_stall", busy_stall, 0);
        read_hl(h, l);
        check("rst_hi", h, 0);
        check("rst_lo", l, 0);
        rst = 1'b1;
        tick();

        run_compute("mult",  4'd1, 32'hFFFFFFFF, 32'd2, 5, 1'b1);
        run_compute("multu", 4'd2, 32'hFFFFFFFF, 32'd2, 5, 1'b1);
        run_compute("div",   4'd3, 32'hFFFFFFF9, 32'd2, 10, 1'b1);
        run_compute("divu",  4'd4, 32'd100, 32'd7, 10, 1'b1);
        mt(4'd5, 32'h1234);
        run_compute("divu0", 4'd4, 32'd5, 32'd0, 10, 1'b1);
        run_compute("divovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 1'b1);
        run_compute("mult_neg", 4'd1, 32'h80000000, 32'h80000000, 5, 1'b1);

        // MTLO and MFLO issued while busy: write ignored, read held off
        model(4'd1, 32'd3, 32'd4);
        sbq.push_back({m_hi, m_lo});
        start = 1'b1; md_op = 4'd1; rs_val = 32'd3; rt_val = 32'd4;
        tick();
        start = 1'b1; md_op = 4'd6; rs_val = 32'hAAAA; rt_val = 32'd0;
        #1 check("mt_busy_stall", busy_stall, 1);
        tick();
        start = 1'b1; md_op = 4'd8; rs_val = 32'd0;
        #1 check("mf_busy_stall", busy_stall, 1);
        tick();
        idle_inputs();
        finish_op("mult_mt", 5, 2);

        // Cancelled start: nothing happens
        start = 1'b1; md_op = 4'd1; rs_val = 32'd5; rt_val = 32'd6; cancel = 1'b1;
        #1 check("cancel_stall", busy_stall, 0);
        tick();
        idle_inputs();
        check("cancel_busy", busy, 0);
        read_hl(h, l);
        check("cancel_hi", h, m_hi);
        check("cancel_lo", l, m_lo);

        // Undefined opcode: no effect
        start = 1'b1; md_op = 4'd13; rs_val = 32'h5555; rt_val = 32'd3;
        tick();
        idle_inputs();
        check("undef_busy", busy, 0);
        read_hl(h, l);
        check("undef_hi", h, m_hi);
        check("undef_lo", l, m_lo);

        // Accumulate op (legal only with MD_MADD_EN)
        mt(4'd5, 32'd0);
        mt(4'd6, 32'hFFFFFFFF);
`ifdef MD_MADD_EN
        madd_n = 5; madd_stall = 1'b1;
`else
        madd_n = 0; madd_stall = 1'b0;
`endif
        run_compute("maddu", 4'd10, 32'd1, 32'd1, madd_n, madd_stall);

        // Reset during busy cycle 3 discards the pending result
        start = 1'b1; md_op = 4'd1; rs_val = 32'd7; rt_val = 32'd9;
        tick();
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        check("midrst_busy", busy, 0);
        read_hl(h, l);
        check("midrst_hi", h, 0);
        check("midrst_lo", l, 0);
        repeat (6) tick();
        check("midrst_busy_later", busy, 0);
        read_hl(h, l);
        check("midrst_hi_later", h, 0);
        check("midrst_lo_later", l, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
